// File: rtl/d_e_pipe_reg.sv
// Decode-to-Execute pipeline register with a W-stage write bypass, a Tnew countdown,
// hold (E stall) and flush (bubble) handling.
module d_e_pipe_reg #(
    parameter logic [31:0] RESET_PC         = 32'h0000_3000,
    parameter int          KEEP_PC_ON_FLUSH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_imm,
    input  logic [4:0]  D_wr_addr,
    input  logic        D_wr_en,
    input  logic [1:0]  D_tnew,
    input  logic        W_we,
    input  logic [4:0]  W_addr,
    input  logic [31:0] W_wd,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [4:0]  E_rs_addr,
    output logic [4:0]  E_rt_addr,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_imm,
    output logic [4:0]  E_wr_addr,
    output logic        E_wr_en,
    output logic [1:0]  E_tnew,
    output logic        E_valid
);

    logic w_live;
    logic rs_bypass, rt_bypass;
    logic rs_refresh, rt_refresh;
    logic wr_live;
    logic [1:0] tnew_next;

    // $0 is hardwired, so a write to it must never be forwarded.
    assign w_live     = W_we && (W_addr != 5'd0);
    assign rs_bypass  = w_live && (W_addr == D_rs_addr);
    assign rt_bypass  = w_live && (W_addr == D_rt_addr);
    assign rs_refresh = E_valid && w_live && (W_addr == E_rs_addr);
    assign rt_refresh = E_valid && w_live && (W_addr == E_rt_addr);
    assign wr_live    = D_wr_en && (D_wr_addr != 5'd0);
    assign tnew_next  = (D_tnew != 2'd0) ? (D_tnew - 2'd1) : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            E_pc      <= RESET_PC;
            E_instr   <= '0;
            E_rs_addr <= '0;
            E_rt_addr <= '0;
            E_rs_data <= '0;
            E_rt_data <= '0;
            E_imm     <= '0;
            E_wr_addr <= '0;
            E_wr_en   <= 1'b0;
            E_tnew    <= '0;
            E_valid   <= 1'b0;
        end else if (flush) begin
            E_pc      <= (KEEP_PC_ON_FLUSH != 0) ? D_pc : RESET_PC;
            E_instr   <= '0;
            E_rs_addr <= '0;
            E_rt_addr <= '0;
            E_rs_data <= '0;
            E_rt_data <= '0;
            E_imm     <= '0;
            E_wr_addr <= '0;
            E_wr_en   <= 1'b0;
            E_tnew    <= '0;
            E_valid   <= 1'b0;
        end else if (en) begin
            E_pc      <= D_pc;
            E_instr   <= D_instr;
            E_rs_addr <= D_rs_addr;
            E_rt_addr <= D_rt_addr;
            E_rs_data <= rs_bypass ? W_wd : D_rs_data;
            E_rt_data <= rt_bypass ? W_wd : D_rt_data;
            E_imm     <= D_imm;
            E_wr_addr <= wr_live ? D_wr_addr : 5'd0;
            E_wr_en   <= wr_live;
            E_tnew    <= tnew_next;
            E_valid   <= 1'b1;
        end else begin
            // Stalled: the W writer is older than the held instruction, so its result must land here.
            if (rs_refresh) E_rs_data <= W_wd;
            if (rt_refresh) E_rt_data <= W_wd;
        end
    end

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Self-checking bench for d_e_pipe_reg: a behavioural model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_d_e_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_imm, W_wd;
    logic [4:0]  D_rs_addr, D_rt_addr, D_wr_addr, W_addr;
    logic        D_wr_en, W_we;
    logic [1:0]  D_tnew;

    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_imm;
    logic [4:0]  E_rs_addr, E_rt_addr, E_wr_addr;
    logic        E_wr_en, E_valid;
    logic [1:0]  E_tnew;

    logic [31:0] F_pc, F_instr, F_rs_data, F_rt_data, F_imm;
    logic [4:0]  F_rs_addr, F_rt_addr, F_wr_addr;
    logic        F_wr_en, F_valid;
    logic [1:0]  F_tnew;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    d_e_pipe_reg #(.RESET_PC(32'h0000_3000), .KEEP_PC_ON_FLUSH(1)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_imm(D_imm),
        .D_wr_addr(D_wr_addr), .D_wr_en(D_wr_en), .D_tnew(D_tnew),
        .W_we(W_we), .W_addr(W_addr), .W_wd(W_wd),
        .E_pc(E_pc), .E_instr(E_instr), .E_rs_addr(E_rs_addr), .E_rt_addr(E_rt_addr),
        .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_imm(E_imm),
        .E_wr_addr(E_wr_addr), .E_wr_en(E_wr_en), .E_tnew(E_tnew), .E_valid(E_valid)
    );

    d_e_pipe_reg #(.RESET_PC(32'h0000_3000), .KEEP_PC_ON_FLUSH(0)) dut_nokeep (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_imm(D_imm),
        .D_wr_addr(D_wr_addr), .D_wr_en(D_wr_en), .D_tnew(D_tnew),
        .W_we(W_we), .W_addr(W_addr), .W_wd(W_wd),
        .E_pc(F_pc), .E_instr(F_instr), .E_rs_addr(F_rs_addr), .E_rt_addr(F_rt_addr),
        .E_rs_data(F_rs_data), .E_rt_data(F_rt_data), .E_imm(F_imm),
        .E_wr_addr(F_wr_addr), .E_wr_en(F_wr_en), .E_tnew(F_tnew), .E_valid(F_valid)
    );

    // Model of what E must hold: one "instruction slot" record plus the two PC views.
    typedef struct {
        logic [31:0] instr, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, wr_addr;
        logic        wr_en, valid;
        int          tnew;
    } slot_t;

    slot_t       m;
    logic [31:0] m_pc_keep, m_pc_nokeep;
    bit          m_known = 0;

    function automatic slot_t bubble();
        slot_t s;
        s.instr = 0; s.rs_data = 0; s.rt_data = 0; s.imm = 0;
        s.rs = 0; s.rt = 0; s.wr_addr = 0; s.wr_en = 0; s.valid = 0; s.tnew = 0;
        return s;
    endfunction

    // The value a register read must see: an in-flight W write to a real register beats the stale read.
    function automatic logic [31:0] forwarded(input logic [4:0] r, input logic [31:0] stale);
        if (W_we && r != 0 && W_addr == r) return W_wd;
        return stale;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m = bubble();
            m_pc_keep = 32'h0000_3000;
            m_pc_nokeep = 32'h0000_3000;
            m_known = 1;
        end else if (flush) begin
            m = bubble();
            m_pc_keep = D_pc;
            m_pc_nokeep = 32'h0000_3000;
        end else if (en) begin
            m.instr   = D_instr;
            m.imm     = D_imm;
            m.rs      = D_rs_addr;
            m.rt      = D_rt_addr;
            m.rs_data = forwarded(D_rs_addr, D_rs_data);
            m.rt_data = forwarded(D_rt_addr, D_rt_data);
            m.wr_en   = D_wr_en && D_wr_addr != 0;
            m.wr_addr = m.wr_en ? D_wr_addr : 5'd0;
            m.tnew    = (int'(D_tnew) > 0) ? int'(D_tnew) - 1 : 0;
            m.valid   = 1;
            m_pc_keep = D_pc;
            m_pc_nokeep = D_pc;
        end else if (m.valid) begin
            m.rs_data = forwarded(m.rs, m.rs_data);
            m.rt_data = forwarded(m.rt, m.rt_data);
        end
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [191:0] pack_model(input logic [31:0] pc);
        return {13'd0, pc, m.instr, m.rs, m.rt, m.rs_data, m.rt_data, m.imm,
                m.wr_addr, m.wr_en, m.tnew[1:0], m.valid};
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_keep", {13'd0, E_pc, E_instr, E_rs_addr, E_rt_addr, E_rs_data, E_rt_data,
                E_imm, E_wr_addr, E_wr_en, E_tnew, E_valid}, pack_model(m_pc_keep));
            chk("model_nokeep", {13'd0, F_pc, F_instr, F_rs_addr, F_rt_addr, F_rs_data, F_rt_data,
                F_imm, F_wr_addr, F_wr_en, F_tnew, F_valid}, pack_model(m_pc_nokeep));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1; flush = 0; W_we = 0; W_addr = 0; W_wd = 0;
        D_pc = 32'h0000_3000; D_instr = 0; D_rs_addr = 0; D_rt_addr = 0;
        D_rs_data = 0; D_rt_data = 0; D_imm = 0; D_wr_addr = 0; D_wr_en = 0; D_tnew = 0;
    endtask

    task automatic rand_d();
        D_pc = $urandom; D_instr = $urandom; D_imm = $urandom;
        D_rs_addr = 5'($urandom_range(0, 7)); D_rt_addr = 5'($urandom_range(0, 7));
        D_rs_data = $urandom; D_rt_data = $urandom;
        D_wr_addr = 5'($urandom_range(0, 7)); D_wr_en = 1'($urandom);
        D_tnew = 2'($urandom);
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        rand_d();
        W_we = 1; W_addr = 5'd3; W_wd = $urandom;
        // 1: reset wins over a live capture
        tick(); tick();
        chk("reset_pc", 192'(E_pc), 192'(32'h0000_3000));
        chk("reset_valid_instr", 192'({E_valid, E_instr}), 192'(0));
        chk("reset_data", 192'({E_rs_data, E_rt_data, E_tnew, E_wr_en}), 192'(0));

        // 2: capture with rs bypassed from W
        reset = 0;
        idle_inputs();
        D_pc = 32'h0000_3004; D_instr = 32'h1234_5678;
        D_rs_addr = 5'd8; D_rs_data = 32'h1111; D_rt_addr = 5'd9; D_rt_data = 32'h2222;
        D_wr_en = 1; D_wr_addr = 5'd10; D_tnew = 2'd2;
        W_we = 1; W_addr = 5'd8; W_wd = 32'hABCD;
        tick();
        chk("bypass_rs", 192'(E_rs_data), 192'(32'hABCD));
        chk("bypass_rt_untouched", 192'(E_rt_data), 192'(32'h2222));
        chk("capture_tnew", 192'(E_tnew), 192'(2'd1));
        chk("capture_valid_wr", 192'({E_valid, E_wr_en, E_wr_addr}), 192'({1'b1, 1'b1, 5'd10}));

        // 3: $0 is never bypassed and never a write target
        idle_inputs();
        D_rs_addr = 0; D_rs_data = 0; D_wr_en = 1; D_wr_addr = 0; D_tnew = 2'd1;
        W_we = 1; W_addr = 0; W_wd = 32'hFFFF_FFFF;
        tick();
        chk("zero_rs_data", 192'(E_rs_data), 192'(0));
        chk("zero_wr", 192'({E_wr_en, E_wr_addr}), 192'(0));

        // 4: hold for three cycles, W writes $5 in the second
        idle_inputs();
        D_pc = 32'h0000_3008; D_instr = 32'hCAFE_0001; D_rt_addr = 5'd5; D_rt_data = 32'h10;
        D_rs_addr = 5'd6; D_rs_data = 32'h66; D_tnew = 2'd3;
        tick();
        en = 0;
        tick();
        chk("hold_c1_rt", 192'(E_rt_data), 192'(32'h10));
        W_we = 1; W_addr = 5'd5; W_wd = 32'h77;
        tick();
        W_we = 0;
        tick();
        chk("hold_refresh_rt", 192'(E_rt_data), 192'(32'h77));
        chk("hold_tnew_kept", 192'(E_tnew), 192'(2'd2));
        chk("hold_fields_kept", 192'({E_pc, E_instr, E_rs_data, E_valid}),
            192'({32'h0000_3008, 32'hCAFE_0001, 32'h66, 1'b1}));

        // 5: flush with en=0
        flush = 1; en = 0; D_pc = 32'h0000_3010;
        W_we = 1; W_addr = 5'd5; W_wd = 32'h99;
        tick();
        chk("flush_pc_keep", 192'(E_pc), 192'(32'h0000_3010));
        chk("flush_pc_nokeep", 192'(F_pc), 192'(32'h0000_3000));
        chk("flush_bubble", 192'({E_instr, E_valid, E_wr_en, E_tnew, E_rt_data}), 192'(0));

        // 6: saturation, then reset beats flush
        idle_inputs();
        D_rs_addr = 5'd4; D_rt_addr = 5'd4; D_rs_data = 1; D_rt_data = 2; D_tnew = 0;
        W_we = 1; W_addr = 5'd4; W_wd = 32'h5555;
        tick();
        chk("tnew_saturate", 192'(E_tnew), 192'(0));
        chk("rs_eq_rt_bypass", 192'({E_rs_data, E_rt_data}), 192'({32'h5555, 32'h5555}));
        reset = 1; flush = 1; D_pc = 32'h0000_3020;
        tick();
        chk("reset_over_flush_keep", 192'({E_pc, E_valid}), 192'({32'h0000_3000, 1'b0}));
        chk("reset_over_flush_nokeep", 192'(F_pc), 192'(32'h0000_3000));
        reset = 0;

        // Mixed traffic, checked by the model each cycle
        for (int i = 0; i < 60; i++) begin
            rand_d();
            en = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            W_we = 1'($urandom); W_addr = 5'($urandom_range(0, 7)); W_wd = $urandom;
            tick();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
